// File: rtl/dec_sub_align_seq.sv
`default_nettype none
// ============================================================================
// Module      : dec_sub_align_seq
// Description : Operand preparation for the BCD floating-point subtractor.
//               Normalises both coefficients (one digit left per cycle),
//               aligns the smaller-exponent operand to the larger exponent
//               (one digit right per cycle, with guard/round/sticky), then
//               hands the pair downstream over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module dec_sub_align_seq #(
    parameter int DIGITS = 7,
    parameter int EXP_W  = 8,
    parameter int GRD    = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [EXP_W-1:0]            e1_in,
    input  logic [EXP_W-1:0]            e2_in,
    input  logic [4*DIGITS-1:0]         m1_in,
    input  logic [4*DIGITS-1:0]         m2_in,
    input  logic                        clear,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [EXP_W-1:0]            e_out,
    output logic [4*(DIGITS+GRD)-1:0]   ma_out,
    output logic [4*(DIGITS+GRD)-1:0]   mb_out,
    output logic                        sticky_out,
    output logic                        swap_out,
    output logic                        busy
);

    localparam int c_MW    = 4 * DIGITS;
    localparam int c_XW    = 4 * (DIGITS + GRD);
    localparam int c_CNT_W = $clog2(DIGITS + 1);

    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DIGITS - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [EXP_W-1:0]   c_E_ONE   = EXP_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_NORM  = 2'd1,
        S_ALIGN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    // Normalisation working registers, one set per operand
    logic [c_MW-1:0]       r_m1;
    logic [c_MW-1:0]       r_m2;
    logic [EXP_W-1:0]      r_e1;
    logic [EXP_W-1:0]      r_e2;
    logic [c_CNT_W-1:0]    r_cnt1;
    logic [c_CNT_W-1:0]    r_cnt2;

    // Alignment registers; these also drive the outputs directly
    logic [c_XW-1:0]       r_ma;
    logic [c_XW-1:0]       r_mb;
    logic [EXP_W-1:0]      r_ea;
    logic [EXP_W-1:0]      r_eb;
    logic                  r_sticky;
    logic                  r_swap;

    logic                  w_accept;
    logic                  w_sh1;
    logic                  w_sh2;
    logic                  w_norm_done;
    logic [EXP_W-1:0]      w_e1_eff;
    logic [EXP_W-1:0]      w_e2_eff;
    logic                  w_swap;
    logic [c_XW-1:0]       w_m1_ext;
    logic [c_XW-1:0]       w_m2_ext;

    assign w_accept = (r_state == S_IDLE) && in_valid && !clear;

    // An operand shifts left only while it has a leading zero digit, is
    // nonzero, has exponent headroom and has not used up its shift budget.
    assign w_sh1 = (r_m1[c_MW-1 -: 4] == 4'd0) && (r_m1 != '0) &&
                   (r_e1 != '0) && (r_cnt1 < c_CNT_MAX);
    assign w_sh2 = (r_m2[c_MW-1 -: 4] == 4'd0) && (r_m2 != '0) &&
                   (r_e2 != '0) && (r_cnt2 < c_CNT_MAX);
    assign w_norm_done = !w_sh1 && !w_sh2;

    // A zero coefficient adopts the other operand's exponent so it never
    // forces an alignment shift; two zeros both take operand 1's exponent.
    assign w_e1_eff = ((r_m1 == '0) && (r_m2 != '0)) ? r_e2 : r_e1;
    assign w_e2_eff = (r_m2 == '0) ? r_e1 : r_e2;
    assign w_swap   = (w_e2_eff > w_e1_eff);

    // Append GRD zero digits below each coefficient
    assign w_m1_ext = c_XW'(r_m1) << (4 * GRD);
    assign w_m2_ext = c_XW'(r_m2) << (4 * GRD);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; clear overrides every transition
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)          w_state_nxt = S_NORM;
            S_NORM:  if (w_norm_done)       w_state_nxt = S_ALIGN;
            S_ALIGN: if (r_eb == r_ea)      w_state_nxt = S_DONE;
            S_DONE:  if (out_ready)         w_state_nxt = S_IDLE;
            default:                        w_state_nxt = S_IDLE;
        endcase
        if (clear) begin
            w_state_nxt = S_IDLE;
        end
    end

    // Datapath: capture, normalise, set up and run the alignment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m1     <= '0;
            r_m2     <= '0;
            r_e1     <= '0;
            r_e2     <= '0;
            r_cnt1   <= '0;
            r_cnt2   <= '0;
            r_ma     <= '0;
            r_mb     <= '0;
            r_ea     <= '0;
            r_eb     <= '0;
            r_sticky <= 1'b0;
            r_swap   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_m1   <= m1_in;
                        r_m2   <= m2_in;
                        r_e1   <= e1_in;
                        r_e2   <= e2_in;
                        r_cnt1 <= '0;
                        r_cnt2 <= '0;
                    end
                end
                S_NORM: begin
                    if (w_sh1) begin
                        r_m1   <= {r_m1[c_MW-5:0], 4'h0};
                        r_e1   <= r_e1 - c_E_ONE;
                        r_cnt1 <= r_cnt1 + c_CNT_ONE;
                    end
                    if (w_sh2) begin
                        r_m2   <= {r_m2[c_MW-5:0], 4'h0};
                        r_e2   <= r_e2 - c_E_ONE;
                        r_cnt2 <= r_cnt2 + c_CNT_ONE;
                    end
                    if (w_norm_done) begin
                        // Tie keeps operand 1 as the larger-exponent side
                        r_swap   <= w_swap;
                        r_ma     <= w_swap ? w_m2_ext : w_m1_ext;
                        r_mb     <= w_swap ? w_m1_ext : w_m2_ext;
                        r_ea     <= w_swap ? w_e2_eff : w_e1_eff;
                        r_eb     <= w_swap ? w_e1_eff : w_e2_eff;
                        r_sticky <= 1'b0;
                    end
                end
                S_ALIGN: begin
                    if (r_eb != r_ea) begin
                        if (r_mb == '0) begin
                            // Nothing left to shift: jump straight to the target
                            r_eb <= r_ea;
                        end else begin
                            r_sticky <= r_sticky | (r_mb[3:0] != 4'd0);
                            r_mb     <= {4'h0, r_mb[c_XW-1:4]};
                            r_eb     <= r_eb + c_E_ONE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready   = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign out_valid  = (r_state == S_DONE);
    assign e_out      = r_ea;
    assign ma_out     = r_ma;
    assign mb_out     = r_mb;
    assign sticky_out = r_sticky;
    assign swap_out   = r_swap;

endmodule
`default_nettype wire

// File: tb/tb_dec_sub_align_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_dec_sub_align_seq
// Description : Directed bench for dec_sub_align_seq with a queue scoreboard
//               fed by a behavioural model of normalise/align.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dec_sub_align_seq;

    typedef struct {
        logic [7:0]  e;
        logic [35:0] ma;
        logic [35:0] mb;
        logic        sticky;
        logic        swap;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        clear = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  e1_in = '0;
    logic [7:0]  e2_in = '0;
    logic [27:0] m1_in = '0;
    logic [27:0] m2_in = '0;
    logic        in_ready;
    logic        out_valid;
    logic        sticky_out;
    logic        swap_out;
    logic        busy;
    logic [7:0]  e_out;
    logic [35:0] ma_out;
    logic [35:0] mb_out;

    int   total = 0;
    int   bad = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    dec_sub_align_seq #(.DIGITS(7), .EXP_W(8), .GRD(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .e1_in      (e1_in),
        .e2_in      (e2_in),
        .m1_in      (m1_in),
        .m2_in      (m2_in),
        .clear      (clear),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .e_out      (e_out),
        .ma_out     (ma_out),
        .mb_out     (mb_out),
        .sticky_out (sticky_out),
        .swap_out   (swap_out),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference model: digit-level normalise, then align with sticky
    function automatic exp_t model(input logic [7:0] e1, input logic [7:0] e2,
                                   input logic [27:0] m1, input logic [27:0] m2);
        exp_t        r;
        int          n;
        int          a;
        int          c1;
        int          c2;
        logic        s1;
        logic        s2;
        logic [7:0]  ea;
        logic [7:0]  eb;
        logic [35:0] xb;
        n = 0; a = 0; c1 = 0; c2 = 0;
        r.sticky = 1'b0;
        for (int k = 0; k < 20; k++) begin
            s1 = (m1[27:24] == 4'd0) && (m1 != 0) && (e1 > 0) && (c1 < 6);
            s2 = (m2[27:24] == 4'd0) && (m2 != 0) && (e2 > 0) && (c2 < 6);
            if (!s1 && !s2) break;
            if (s1) begin m1 = m1 << 4; e1 = e1 - 8'd1; c1++; end
            if (s2) begin m2 = m2 << 4; e2 = e2 - 8'd1; c2++; end
            n++;
        end
        if (m1 == 0 && m2 == 0)  e2 = e1;
        else if (m1 == 0)        e1 = e2;
        else if (m2 == 0)        e2 = e1;
        r.swap = (e2 > e1);
        ea   = r.swap ? e2 : e1;
        eb   = r.swap ? e1 : e2;
        r.ma = {(r.swap ? m2 : m1), 8'h00};
        xb   = {(r.swap ? m1 : m2), 8'h00};
        for (int k = 0; k < 300; k++) begin
            if (eb >= ea) break;
            a++;
            if (xb == 0) begin
                eb = ea;
            end else begin
                r.sticky = r.sticky | (xb[3:0] != 4'd0);
                xb = xb >> 4;
                eb = eb + 8'd1;
            end
        end
        r.e   = ea;
        r.mb  = xb;
        r.lat = n + a + 3;
        return r;
    endfunction

    // Present one pair; returns #1 after the accepting edge
    task automatic start(input logic [7:0] a_e1, input logic [7:0] a_e2,
                         input logic [27:0] a_m1, input logic [27:0] a_m2, input bit push);
        @(negedge clk);
        chk("in_ready_idle", in_ready, 1);
        e1_in = a_e1; e2_in = a_e2; m1_in = a_m1; m2_in = a_m2;
        in_valid = 1'b1;
        if (push) sb.push_back(model(a_e1, a_e2, a_m1, a_m2));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Wait for out_valid, score it, optionally stall, then complete the transfer
    task automatic collect(input int stall);
        int   lat;
        exp_t x;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("out_valid_seen", out_valid, 1);
        x = '{e: 8'h0, ma: 36'h0, mb: 36'h0, sticky: 1'b0, swap: 1'b0, lat: 0};
        if (sb.size() == 0) begin
            chk("scoreboard_nonempty", 0, 1);
        end else begin
            x = sb.pop_front();
            chk("latency", lat, x.lat);
            chk("e_out", e_out, x.e);
            chk("ma_out", ma_out, x.ma);
            chk("mb_out", mb_out, x.mb);
            chk("sticky_out", sticky_out, x.sticky);
            chk("swap_out", swap_out, x.swap);
        end
        for (int k = 0; k < stall; k++) begin
            in_valid = 1'b1; e1_in = 8'hff; m1_in = 28'h9999999;
            @(posedge clk); #1;
            chk("stall_valid", out_valid, 1);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_ma", ma_out, x.ma);
            chk("stall_mb", mb_out, x.mb);
            chk("stall_e", e_out, x.e);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("post_xfer_valid", out_valid, 0);
        chk("post_xfer_ready", in_ready, 1);
    endtask

    initial begin
        int seen;
        // Reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_e_out", e_out, 0);
        chk("rst_ma", ma_out, 0);
        chk("rst_mb", mb_out, 0);
        chk("rst_sticky", sticky_out, 0);
        chk("rst_swap", swap_out, 0);

        // Both normalised, equal exponent
        start(8'd100, 8'd100, 28'h1234567, 28'h7654321, 1'b1);
        collect(0);
        // Leading zeros on operand 1
        start(8'd50, 8'd46, 28'h0000123, 28'h1000000, 1'b1);
        collect(0);
        // Exponent floor stops normalisation
        start(8'd2, 8'd0, 28'h0000045, 28'h0000001, 1'b1);
        collect(0);
        // Far alignment with sticky, plus a 5-cycle downstream stall
        start(8'd120, 8'd100, 28'h9999999, 28'h5000001, 1'b1);
        collect(5);
        // Operand 2 ends up larger: swap
        start(8'd10, 8'd30, 28'h0000050, 28'h0312000, 1'b1);
        collect(0);
        // Zero coefficient adopts the other exponent
        start(8'd5, 8'd80, 28'h0000000, 28'h0001234, 1'b1);
        collect(0);

        // Abort with clear in the second NORM cycle
        start(8'd50, 8'd46, 28'h0000123, 28'h1000000, 1'b0);
        @(posedge clk); #1;
        chk("abort_busy_norm", busy, 1);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1;
        end
        chk("abort_no_valid", seen, 0);

        // Reset mid-ALIGN
        start(8'd120, 8'd100, 28'h9999999, 28'h5000001, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_ma", ma_out, 36'h999999900);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_e_out", e_out, 0);
        chk("midrst_ma", ma_out, 0);
        chk("midrst_mb", mb_out, 0);
        chk("midrst_sticky", sticky_out, 0);
        chk("midrst_swap", swap_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("postrst_in_ready", in_ready, 1);
        chk("postrst_busy", busy, 0);

        // Normal operation after reset
        start(8'd100, 8'd100, 28'h1234567, 28'h7654321, 1'b1);
        collect(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
